axi_mem_arbiter: RTL and testbench

//  2-master -> 1-slave AXI4 arbiter sharing the single memory/peripheral port between IFU (m0, read-only)
//  and LSU (m1, read/write). One transaction is outstanding system-wide: grant is taken on request and

---
 rtl/axi_mem_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_axi_mem_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4 arbiter, one transaction outstanding.
// Define ARB_ROUND_ROBIN_EN to alternate m0/m1 on conflicting requests instead of fixed priority.
module axi_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                i_clock,
    input  logic                i_reset,
    // IFU read
    input  logic [ADDR_W-1:0]   i_m0_araddr,
    input  logic                i_m0_arvalid,
    input  logic [ID_W-1:0]     i_m0_arid,
    input  logic [7:0]          i_m0_arlen,
    input  logic [2:0]          i_m0_arsize,
    input  logic [1:0]          i_m0_arburst,
    output logic                o_m0_arready,
    output logic [DATA_W-1:0]   o_m0_rdata,
    output logic                o_m0_rvalid,
    output logic [1:0]          o_m0_rresp,
    output logic                o_m0_rlast,
    output logic [ID_W-1:0]     o_m0_rid,
    input  logic                i_m0_rready,
    // LSU read
    input  logic [ADDR_W-1:0]   i_m1_araddr,
    input  logic                i_m1_arvalid,
    input  logic [ID_W-1:0]     i_m1_arid,
    input  logic [7:0]          i_m1_arlen,
    input  logic [2:0]          i_m1_arsize,
    input  logic [1:0]          i_m1_arburst,
    output logic                o_m1_arready,
    output logic [DATA_W-1:0]   o_m1_rdata,
    output logic                o_m1_rvalid,
    output logic [1:0]          o_m1_rresp,
    output logic                o_m1_rlast,
    output logic [ID_W-1:0]     o_m1_rid,
    input  logic                i_m1_rready,
    // LSU write
    input  logic [ADDR_W-1:0]   i_m1_awaddr,
    input  logic                i_m1_awvalid,
    input  logic [ID_W-1:0]     i_m1_awid,
    input  logic [7:0]          i_m1_awlen,
    input  logic [2:0]          i_m1_awsize,
    input  logic [1:0]          i_m1_awburst,
    output logic                o_m1_awready,
    input  logic [DATA_W-1:0]   i_m1_wdata,
    input  logic [DATA_W/8-1:0] i_m1_wstrb,
    input  logic                i_m1_wvalid,
    input  logic                i_m1_wlast,
    output logic                o_m1_wready,
    output logic [1:0]          o_m1_bresp,
    output logic                o_m1_bvalid,
    output logic [ID_W-1:0]     o_m1_bid,
    input  logic                i_m1_bready,
    // slave read
    output logic [ADDR_W-1:0]   o_s_araddr,
    output logic                o_s_arvalid,
    output logic [ID_W-1:0]     o_s_arid,
    output logic [7:0]          o_s_arlen,
    output logic [2:0]          o_s_arsize,
    output logic [1:0]          o_s_arburst,
    input  logic                i_s_arready,
    input  logic [DATA_W-1:0]   i_s_rdata,
    input  logic                i_s_rvalid,
    input  logic [1:0]          i_s_rresp,
    input  logic                i_s_rlast,
    input  logic [ID_W-1:0]     i_s_rid,
    output logic                o_s_rready,
    // slave write
    output logic [ADDR_W-1:0]   o_s_awaddr,
    output logic                o_s_awvalid,
    output logic [ID_W-1:0]     o_s_awid,
    output logic [7:0]          o_s_awlen,
    output logic [2:0]          o_s_awsize,
    output logic [1:0]          o_s_awburst,
    input  logic                i_s_awready,
    output logic [DATA_W-1:0]   o_s_wdata,
    output logic [DATA_W/8-1:0] o_s_wstrb,
    output logic                o_s_wvalid,
    output logic                o_s_wlast,
    input  logic                i_s_wready,
    input  logic [1:0]          i_s_bresp,
    input  logic                i_s_bvalid,
    input  logic [ID_W-1:0]     i_s_bid,
    output logic                o_s_bready,
    output logic [1:0]          o_grant
);

    typedef enum logic [1:0] {IDLE, M0_RD, M1_RD, M1_WR} state_t;

    state_t     state;
    state_t     idle_next;
    logic [1:0] grant_q;
    logic       ar_done;
    logic       aw_done;
    logic       w_done;
    logic       m0_rd, m1_rd, m1_wr;
    logic       m0_r_en, m1_r_en;
    logic       r_last_hs, b_hs;

    function automatic logic [1:0] grant_code(input state_t s);
        case (s)
            M0_RD:        grant_code = 2'b01;
            M1_RD, M1_WR: grant_code = 2'b10;
            default:      grant_code = 2'b00;
        endcase
    endfunction

`ifdef ARB_ROUND_ROBIN_EN
    logic last_m1;

    // m1 wins unless m0 is also waiting and m1 was the last one served
    always_comb begin
        idle_next = IDLE;
        if ((i_m1_awvalid || i_m1_arvalid) && (!i_m0_arvalid || !last_m1))
            idle_next = i_m1_awvalid ? M1_WR : M1_RD;
        else if (i_m0_arvalid)
            idle_next = M0_RD;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            last_m1 <= 1'b0;
        else if (state == IDLE && idle_next != IDLE)
            last_m1 <= (idle_next != M0_RD);
    end
`else
    always_comb begin
        idle_next = IDLE;
        if (i_m1_awvalid)
            idle_next = M1_WR;
        else if (i_m1_arvalid)
            idle_next = M1_RD;
        else if (i_m0_arvalid)
            idle_next = M0_RD;
    end
`endif

    assign m0_rd   = (state == M0_RD);
    assign m1_rd   = (state == M1_RD);
    assign m1_wr   = (state == M1_WR);
    assign m0_r_en = m0_rd && ar_done;
    assign m1_r_en = m1_rd && ar_done;

    // AR: granted master's address goes out once, then the channel is closed
    assign o_s_araddr   = m0_rd ? i_m0_araddr  : (m1_rd ? i_m1_araddr  : '0);
    assign o_s_arid     = m0_rd ? i_m0_arid    : (m1_rd ? i_m1_arid    : '0);
    assign o_s_arlen    = m0_rd ? i_m0_arlen   : (m1_rd ? i_m1_arlen   : '0);
    assign o_s_arsize   = m0_rd ? i_m0_arsize  : (m1_rd ? i_m1_arsize  : '0);
    assign o_s_arburst  = m0_rd ? i_m0_arburst : (m1_rd ? i_m1_arburst : '0);
    assign o_s_arvalid  = !ar_done && ((m0_rd && i_m0_arvalid) || (m1_rd && i_m1_arvalid));
    assign o_m0_arready = m0_rd && !ar_done && i_s_arready;
    assign o_m1_arready = m1_rd && !ar_done && i_s_arready;

    // R: beats only reach the owner once its address has been accepted
    assign o_m0_rvalid = m0_r_en && i_s_rvalid;
    assign o_m0_rdata  = m0_r_en ? i_s_rdata : '0;
    assign o_m0_rresp  = m0_r_en ? i_s_rresp : '0;
    assign o_m0_rlast  = m0_r_en && i_s_rlast;
    assign o_m0_rid    = m0_r_en ? i_s_rid   : '0;
    assign o_m1_rvalid = m1_r_en && i_s_rvalid;
    assign o_m1_rdata  = m1_r_en ? i_s_rdata : '0;
    assign o_m1_rresp  = m1_r_en ? i_s_rresp : '0;
    assign o_m1_rlast  = m1_r_en && i_s_rlast;
    assign o_m1_rid    = m1_r_en ? i_s_rid   : '0;
    assign o_s_rready  = (m0_r_en && i_m0_rready) || (m1_r_en && i_m1_rready);

    // AW, W and B are independent within a write grant
    assign o_s_awaddr   = m1_wr ? i_m1_awaddr  : '0;
    assign o_s_awid     = m1_wr ? i_m1_awid    : '0;
    assign o_s_awlen    = m1_wr ? i_m1_awlen   : '0;
    assign o_s_awsize   = m1_wr ? i_m1_awsize  : '0;
    assign o_s_awburst  = m1_wr ? i_m1_awburst : '0;
    assign o_s_awvalid  = m1_wr && !aw_done && i_m1_awvalid;
    assign o_m1_awready = m1_wr && !aw_done && i_s_awready;
    assign o_s_wdata    = m1_wr ? i_m1_wdata : '0;
    assign o_s_wstrb    = m1_wr ? i_m1_wstrb : '0;
    assign o_s_wlast    = m1_wr && i_m1_wlast;
    assign o_s_wvalid   = m1_wr && !w_done && i_m1_wvalid;
    assign o_m1_wready  = m1_wr && !w_done && i_s_wready;
    assign o_m1_bvalid  = m1_wr && i_s_bvalid;
    assign o_m1_bresp   = m1_wr ? i_s_bresp : '0;
    assign o_m1_bid     = m1_wr ? i_s_bid   : '0;
    assign o_s_bready   = m1_wr && i_m1_bready;

    assign o_grant   = grant_q;
    assign r_last_hs = i_s_rvalid && o_s_rready && i_s_rlast;
    assign b_hs      = o_m1_bvalid && i_m1_bready;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state   <= IDLE;
            grant_q <= 2'b00;
            ar_done <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state   <= idle_next;
                    grant_q <= grant_code(idle_next);
                    ar_done <= 1'b0;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end
                M0_RD, M1_RD: begin
                    if (o_s_arvalid && i_s_arready)
                        ar_done <= 1'b1;
                    if (r_last_hs) begin
                        state   <= IDLE;
                        grant_q <= 2'b00;
                        ar_done <= 1'b0;
                    end
                end
                M1_WR: begin
                    if (o_s_awvalid && i_s_awready)
                        aw_done <= 1'b1;
                    if (o_s_wvalid && i_s_wready && i_m1_wlast)
                        w_done <= 1'b1;
                    if (b_hs) begin
                        state   <= IDLE;
                        grant_q <= 2'b00;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter: R/B beats are checked against a queue of expected responses.
module tb_axi_mem_arbiter;

    logic        i_clock;
    logic        i_reset;
    logic [31:0] i_m0_araddr;  logic i_m0_arvalid; logic [3:0] i_m0_arid;
    logic [7:0]  i_m0_arlen;   logic [2:0] i_m0_arsize; logic [1:0] i_m0_arburst;
    logic        o_m0_arready;
    logic [31:0] o_m0_rdata;   logic o_m0_rvalid; logic [1:0] o_m0_rresp; logic o_m0_rlast;
    logic [3:0]  o_m0_rid;     logic i_m0_rready;
    logic [31:0] i_m1_araddr;  logic i_m1_arvalid; logic [3:0] i_m1_arid;
    logic [7:0]  i_m1_arlen;   logic [2:0] i_m1_arsize; logic [1:0] i_m1_arburst;
    logic        o_m1_arready;
    logic [31:0] o_m1_rdata;   logic o_m1_rvalid; logic [1:0] o_m1_rresp; logic o_m1_rlast;
    logic [3:0]  o_m1_rid;     logic i_m1_rready;
    logic [31:0] i_m1_awaddr;  logic i_m1_awvalid; logic [3:0] i_m1_awid;
    logic [7:0]  i_m1_awlen;   logic [2:0] i_m1_awsize; logic [1:0] i_m1_awburst;
    logic        o_m1_awready;
    logic [31:0] i_m1_wdata;   logic [3:0] i_m1_wstrb; logic i_m1_wvalid; logic i_m1_wlast;
    logic        o_m1_wready;
    logic [1:0]  o_m1_bresp;   logic o_m1_bvalid; logic [3:0] o_m1_bid; logic i_m1_bready;
    logic [31:0] o_s_araddr;   logic o_s_arvalid; logic [3:0] o_s_arid;
    logic [7:0]  o_s_arlen;    logic [2:0] o_s_arsize; logic [1:0] o_s_arburst;
    logic        i_s_arready;
    logic [31:0] i_s_rdata;    logic i_s_rvalid; logic [1:0] i_s_rresp; logic i_s_rlast;
    logic [3:0]  i_s_rid;      logic o_s_rready;
    logic [31:0] o_s_awaddr;   logic o_s_awvalid; logic [3:0] o_s_awid;
    logic [7:0]  o_s_awlen;    logic [2:0] o_s_awsize; logic [1:0] o_s_awburst;
    logic        i_s_awready;
    logic [31:0] o_s_wdata;    logic [3:0] o_s_wstrb; logic o_s_wvalid; logic o_s_wlast;
    logic        i_s_wready;
    logic [1:0]  i_s_bresp;    logic i_s_bvalid; logic [3:0] i_s_bid; logic o_s_bready;
    logic [1:0]  o_grant;

    axi_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_m0_araddr(i_m0_araddr), .i_m0_arvalid(i_m0_arvalid), .i_m0_arid(i_m0_arid),
        .i_m0_arlen(i_m0_arlen), .i_m0_arsize(i_m0_arsize), .i_m0_arburst(i_m0_arburst),
        .o_m0_arready(o_m0_arready),
        .o_m0_rdata(o_m0_rdata), .o_m0_rvalid(o_m0_rvalid), .o_m0_rresp(o_m0_rresp),
        .o_m0_rlast(o_m0_rlast), .o_m0_rid(o_m0_rid), .i_m0_rready(i_m0_rready),
        .i_m1_araddr(i_m1_araddr), .i_m1_arvalid(i_m1_arvalid), .i_m1_arid(i_m1_arid),
        .i_m1_arlen(i_m1_arlen), .i_m1_arsize(i_m1_arsize), .i_m1_arburst(i_m1_arburst),
        .o_m1_arready(o_m1_arready),
        .o_m1_rdata(o_m1_rdata), .o_m1_rvalid(o_m1_rvalid), .o_m1_rresp(o_m1_rresp),
        .o_m1_rlast(o_m1_rlast), .o_m1_rid(o_m1_rid), .i_m1_rready(i_m1_rready),
        .i_m1_awaddr(i_m1_awaddr), .i_m1_awvalid(i_m1_awvalid), .i_m1_awid(i_m1_awid),
        .i_m1_awlen(i_m1_awlen), .i_m1_awsize(i_m1_awsize), .i_m1_awburst(i_m1_awburst),
        .o_m1_awready(o_m1_awready),
        .i_m1_wdata(i_m1_wdata), .i_m1_wstrb(i_m1_wstrb), .i_m1_wvalid(i_m1_wvalid),
        .i_m1_wlast(i_m1_wlast), .o_m1_wready(o_m1_wready),
        .o_m1_bresp(o_m1_bresp), .o_m1_bvalid(o_m1_bvalid), .o_m1_bid(o_m1_bid),
        .i_m1_bready(i_m1_bready),
        .o_s_araddr(o_s_araddr), .o_s_arvalid(o_s_arvalid), .o_s_arid(o_s_arid),
        .o_s_arlen(o_s_arlen), .o_s_arsize(o_s_arsize), .o_s_arburst(o_s_arburst),
        .i_s_arready(i_s_arready),
        .i_s_rdata(i_s_rdata), .i_s_rvalid(i_s_rvalid), .i_s_rresp(i_s_rresp),
        .i_s_rlast(i_s_rlast), .i_s_rid(i_s_rid), .o_s_rready(o_s_rready),
        .o_s_awaddr(o_s_awaddr), .o_s_awvalid(o_s_awvalid), .o_s_awid(o_s_awid),
        .o_s_awlen(o_s_awlen), .o_s_awsize(o_s_awsize), .o_s_awburst(o_s_awburst),
        .i_s_awready(i_s_awready),
        .o_s_wdata(o_s_wdata), .o_s_wstrb(o_s_wstrb), .o_s_wvalid(o_s_wvalid),
        .o_s_wlast(o_s_wlast), .i_s_wready(i_s_wready),
        .i_s_bresp(i_s_bresp), .i_s_bvalid(i_s_bvalid), .i_s_bid(i_s_bid),
        .o_s_bready(o_s_bready),
        .o_grant(o_grant)
    );

    typedef struct {
        logic        mst;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } r_exp_t;

    typedef struct {
        logic [1:0] resp;
        logic [3:0] id;
    } b_exp_t;

    r_exp_t rq[$];
    b_exp_t bq[$];
    int     errors = 0;
    int     checks = 0;

    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_r(input logic mst, input logic [31:0] data, input logic [1:0] resp,
                           input logic last, input logic [3:0] id);
        r_exp_t e;
        chk("r_expected_beat", 64'(rq.size() != 0), 64'(1));
        if (rq.size() != 0) begin
            e = rq.pop_front();
            chk("r_master", 64'(mst),  64'(e.mst));
            chk("r_data",   64'(data), 64'(e.data));
            chk("r_resp",   64'(resp), 64'(e.resp));
            chk("r_last",   64'(last), 64'(e.last));
            chk("r_id",     64'(id),   64'(e.id));
        end
    endtask

    // response monitor: every delivered beat must match the next expected one
    always @(negedge i_clock) begin
        if (!i_reset) begin
            if (o_m0_rvalid && i_m0_rready)
                check_r(1'b0, o_m0_rdata, o_m0_rresp, o_m0_rlast, o_m0_rid);
            if (o_m1_rvalid && i_m1_rready)
                check_r(1'b1, o_m1_rdata, o_m1_rresp, o_m1_rlast, o_m1_rid);
            if (o_m1_bvalid && i_m1_bready) begin
                b_exp_t be;
                chk("b_expected", 64'(bq.size() != 0), 64'(1));
                if (bq.size() != 0) begin
                    be = bq.pop_front();
                    chk("b_resp", 64'(o_m1_bresp), 64'(be.resp));
                    chk("b_id",   64'(o_m1_bid),   64'(be.id));
                end
            end
        end
    end

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    // Caller leaves the request asserted with the FSM idle; returns at the negedge after completion.
    task automatic read_grant(input logic who, input logic [31:0] addr,
                              input logic [31:0] data, input logic [1:0] resp);
        logic [3:0] id;
        r_exp_t     e;
        id = who ? 4'hA : 4'h3;
        tick();
        @(negedge i_clock);
        chk("rd_grant",     64'(o_grant),     64'(who ? 2'b10 : 2'b01));
        chk("rd_s_arvalid", 64'(o_s_arvalid), 64'(1));
        chk("rd_s_araddr",  64'(o_s_araddr),  64'(addr));
        chk("rd_s_arid",    64'(o_s_arid),    64'(id));
        chk("rd_win_ready", 64'(who ? o_m1_arready : o_m0_arready), 64'(1));
        chk("rd_lose_ready", 64'(who ? o_m0_arready : o_m1_arready), 64'(0));
        tick();
        if (who) begin i_m1_arvalid = 1'b0; i_m1_rready = 1'b1; end
        else     begin i_m0_arvalid = 1'b0; i_m0_rready = 1'b1; end
        i_s_rvalid = 1'b1; i_s_rdata = data; i_s_rresp = resp; i_s_rlast = 1'b1; i_s_rid = id;
        e.mst = who; e.data = data; e.resp = resp; e.last = 1'b1; e.id = id;
        rq.push_back(e);
        @(negedge i_clock);
        chk("rd_ar_once",   64'(o_s_arvalid), 64'(0));
        chk("rd_grant_held", 64'(o_grant),    64'(who ? 2'b10 : 2'b01));
        tick();
        i_s_rvalid = 1'b0; i_s_rlast = 1'b0; i_m0_rready = 1'b0; i_m1_rready = 1'b0;
        @(negedge i_clock);
        chk("rd_grant_idle", 64'(o_grant), 64'(0));
        chk("rd_idle_arready", 64'(o_m0_arready | o_m1_arready), 64'(0));
    endtask

    initial begin
        int     beat;
        logic   hs;
        r_exp_t e;
        b_exp_t be;

        i_reset = 1'b1;
        i_m0_araddr = '0; i_m0_arvalid = 0; i_m0_arid = 4'h3; i_m0_arlen = '0;
        i_m0_arsize = 3'd2; i_m0_arburst = 2'b01; i_m0_rready = 0;
        i_m1_araddr = '0; i_m1_arvalid = 0; i_m1_arid = 4'hA; i_m1_arlen = '0;
        i_m1_arsize = 3'd2; i_m1_arburst = 2'b01; i_m1_rready = 0;
        i_m1_awaddr = '0; i_m1_awvalid = 0; i_m1_awid = 4'h5; i_m1_awlen = '0;
        i_m1_awsize = 3'd2; i_m1_awburst = 2'b01;
        i_m1_wdata = '0; i_m1_wstrb = '0; i_m1_wvalid = 0; i_m1_wlast = 0; i_m1_bready = 0;
        i_s_arready = 0; i_s_rdata = '0; i_s_rvalid = 0; i_s_rresp = '0; i_s_rlast = 0;
        i_s_rid = '0; i_s_awready = 0; i_s_wready = 0; i_s_bresp = '0; i_s_bvalid = 0;
        i_s_bid = '0;

        // reset state
        @(negedge i_clock);
        chk("rst_grant",    64'(o_grant),     64'(0));
        chk("rst_s_arvalid", 64'(o_s_arvalid), 64'(0));
        chk("rst_s_awvalid", 64'(o_s_awvalid), 64'(0));
        chk("rst_s_wvalid", 64'(o_s_wvalid),  64'(0));
        chk("rst_readies",  64'({o_m0_arready, o_m1_arready, o_m1_awready, o_m1_wready,
                                 o_s_rready, o_s_bready}), 64'(0));
        chk("rst_valids",   64'({o_m0_rvalid, o_m1_rvalid, o_m1_bvalid}), 64'(0));
        tick();
        i_reset = 1'b0;

        // single-beat m0 read
        i_m0_arvalid = 1'b1; i_m0_araddr = 32'h8000_0000; i_s_arready = 1'b1;
        @(negedge i_clock);
        chk("idle_m0_arready", 64'(o_m0_arready), 64'(0));
        chk("idle_grant",      64'(o_grant),      64'(0));
        chk("idle_s_arvalid",  64'(o_s_arvalid),  64'(0));
        read_grant(1'b0, 32'h8000_0000, 32'hDEAD_BEEF, 2'b00);

        // m0/m1 read conflict, then m1 asks again while m0 is still waiting
        #1;
        i_m0_arvalid = 1'b1; i_m0_araddr = 32'h0000_1000;
        i_m1_arvalid = 1'b1; i_m1_araddr = 32'h0000_2000;
        read_grant(1'b1, 32'h0000_2000, 32'h1111_2222, 2'b00);
        #1;
        i_m1_arvalid = 1'b1; i_m1_araddr = 32'h0000_3000;
`ifdef ARB_ROUND_ROBIN_EN
        read_grant(1'b0, 32'h0000_1000, 32'h3333_4444, 2'b00);
        read_grant(1'b1, 32'h0000_3000, 32'h5555_6666, 2'b00);
`else
        read_grant(1'b1, 32'h0000_3000, 32'h5555_6666, 2'b00);
        read_grant(1'b0, 32'h0000_1000, 32'h3333_4444, 2'b00);
`endif

        // write with W ahead of AW, m0 read stalled behind it
        #1;
        i_m1_awvalid = 1'b1; i_m1_awaddr = 32'h8000_0010;
        i_m1_wvalid = 1'b1; i_m1_wdata = 32'h1234_5678; i_m1_wstrb = 4'b0011; i_m1_wlast = 1'b1;
        i_m1_bready = 1'b1; i_s_awready = 1'b0; i_s_wready = 1'b1;
        tick();
        @(negedge i_clock);
        chk("wr_grant",    64'(o_grant),      64'(2'b10));
        chk("wr_s_wvalid", 64'(o_s_wvalid),   64'(1));
        chk("wr_s_wdata",  64'(o_s_wdata),    64'(32'h1234_5678));
        chk("wr_s_wstrb",  64'(o_s_wstrb),    64'(4'b0011));
        chk("wr_awvalid",  64'(o_s_awvalid),  64'(1));
        chk("wr_awready_wait", 64'(o_m1_awready), 64'(0));
        tick();
        i_m1_wvalid = 1'b0; i_m1_wlast = 1'b0;
        i_m0_arvalid = 1'b1; i_m0_araddr = 32'h0000_4000;
        @(negedge i_clock);
        chk("wr_w_once",    64'(o_s_wvalid | o_m1_wready), 64'(0));
        chk("wr_m0_stall",  64'(o_m0_arready | o_s_arvalid), 64'(0));
        tick();
        @(negedge i_clock);
        chk("wr_aw_pending", 64'(o_s_awvalid), 64'(1));
        tick();
        i_s_awready = 1'b1;
        @(negedge i_clock);
        chk("wr_awready",  64'(o_m1_awready), 64'(1));
        chk("wr_s_awaddr", 64'(o_s_awaddr),   64'(32'h8000_0010));
        chk("wr_s_awid",   64'(o_s_awid),     64'(4'h5));
        tick();
        i_m1_awvalid = 1'b0; i_s_awready = 1'b0;
        i_s_bvalid = 1'b1; i_s_bresp = 2'b00; i_s_bid = 4'h5;
        be.resp = 2'b00; be.id = 4'h5;
        bq.push_back(be);
        @(negedge i_clock);
        chk("wr_aw_once",  64'(o_s_awvalid),  64'(0));
        chk("wr_bvalid",   64'(o_m1_bvalid),  64'(1));
        chk("wr_m0_stall_b", 64'(o_m0_arready), 64'(0));
        chk("wr_grant_b",  64'(o_grant),      64'(2'b10));
        tick();
        i_s_bvalid = 1'b0; i_m1_bready = 1'b0;
        @(negedge i_clock);
        chk("wr_grant_idle", 64'(o_grant), 64'(0));
        read_grant(1'b0, 32'h0000_4000, 32'h7777_8888, 2'b00);

        // 4-beat m0 burst with a stalling master; early slave data must be ignored
        #1;
        i_m0_arvalid = 1'b1; i_m0_araddr = 32'h0000_5000; i_m0_arlen = 8'd3;
        tick();
        i_s_rvalid = 1'b1; i_s_rdata = 32'h0BAD_0BAD; i_s_rlast = 1'b1; i_s_rid = 4'h3;
        i_m0_rready = 1'b1;
        @(negedge i_clock);
        chk("burst_arlen",    64'(o_s_arlen),   64'(3));
        chk("burst_early_r",  64'(o_m0_rvalid | o_s_rready), 64'(0));
        tick();
        i_m0_arvalid = 1'b0; i_m0_arlen = '0; i_m0_rready = 1'b0; i_s_rvalid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            e.mst = 1'b0; e.data = 32'hA000_0000 + 32'(b); e.resp = 2'b00;
            e.last = (b == 3); e.id = 4'h3;
            rq.push_back(e);
        end
        beat = 0;
        for (int cyc = 0; cyc < 40 && beat < 4; cyc++) begin
            i_s_rvalid = 1'b1; i_s_rdata = 32'hA000_0000 + 32'(beat);
            i_s_rlast = (beat == 3); i_m0_rready = ((cyc % 2) == 1);
            @(negedge i_clock);
            chk("burst_grant_held", 64'(o_grant), 64'(2'b01));
            hs = o_s_rready && i_s_rvalid;
            tick();
            if (hs) beat++;
        end
        i_s_rvalid = 1'b0; i_s_rlast = 1'b0; i_m0_rready = 1'b0;
        @(negedge i_clock);
        chk("burst_beats",      64'(beat),      64'(4));
        chk("burst_grant_idle", 64'(o_grant),   64'(0));
        chk("burst_q_empty",    64'(rq.size()), 64'(0));

        // DECERR on m1 read passes through, flow unchanged
        #1;
        i_m1_arvalid = 1'b1; i_m1_araddr = 32'hF000_0000;
        read_grant(1'b1, 32'hF000_0000, 32'h0BAD_F00D, 2'b11);

        // reset in the middle of an R beat
        #1;
        i_m0_arvalid = 1'b1; i_m0_araddr = 32'h0000_6000;
        tick();
        tick();
        i_m0_arvalid = 1'b0; i_m0_rready = 1'b1;
        i_s_rvalid = 1'b1; i_s_rdata = 32'hCAFE_F00D; i_s_rlast = 1'b1; i_s_rid = 4'h3;
        #2;
        i_reset = 1'b1;
        #1;
        chk("mid_rst_grant",  64'(o_grant),     64'(0));
        chk("mid_rst_rvalid", 64'(o_m0_rvalid), 64'(0));
        chk("mid_rst_rready", 64'(o_s_rready),  64'(0));
        tick();
        i_reset = 1'b0; i_s_rvalid = 1'b0; i_s_rlast = 1'b0; i_m0_rready = 1'b0;
        @(negedge i_clock);
        chk("post_rst_grant", 64'(o_grant), 64'(0));
        #1;
        i_m0_arvalid = 1'b1; i_m0_araddr = 32'h0000_7000;
        read_grant(1'b0, 32'h0000_7000, 32'h2468_ACE0, 2'b01);

        @(negedge i_clock);
        chk("final_r_q_empty", 64'(rq.size()), 64'(0));
        chk("final_b_q_empty", 64'(bq.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
